flat_vec_streamer: RTL and testbench
====================================

Name: flat_vec_streamer

Overview:
- Transmitter side of the flat tensor-vector interface used between yolo layers.
- Captures one complete flat CHW vector, such as the out_vec of a bottleneck or yolo_conv stage, in a single handshake.
- Replays it one WIDTH-bit element per beat over a valid/ready stream, with position tags.
- Feeds off-chip links, debug taps and time-multiplexed downstream layers that cannot take the full-width vector.

Parameters:
- CH, default 1: channels in the vector.
- H, default 1: feature-map height.
- W, default 1: feature-map width.
- WIDTH, default 16: bits per element (Q8.8 default; data is passed through unmodified).
- DIM, default CH*H*W: element count. Derived; must not be overridden.

Ports:
- clk, input, 1: clock, all logic on rising edge.
- rst_n, input, 1: synchronous active-low reset.
- vec_valid, input, 1: vec_in holds a vector to send.
- vec_ready, output, 1: streamer accepts vec_in this cycle.
- vec_in, input, DIM*WIDTH: flat vector. Element i sits at bits [i*WIDTH +: WIDTH], with i = (c*H + r)*W + x.
- s_valid, output, 1: stream beat valid.
- s_ready, input, 1: downstream accepts beat.
- s_data, output, WIDTH: element value, signed, bit-exact copy.
- s_first, output, 1: beat is element 0.
- s_last, output, 1: beat is element DIM-1.
- s_ch, output, max(1,$clog2(CH)): channel index c of the current beat.
- s_row, output, max(1,$clog2(H)): row index r.
- s_col, output, max(1,$clog2(W)): column index x.

Behaviour:
- Reset: while rst_n=0 at a clk edge the block goes to IDLE.
  - idx, c, r and x counters clear to 0.
  - s_valid=0, s_data=0, s_first/s_last=0, s_ch/s_row/s_col=0.
  - vec_ready is forced 0 while rst_n is low.
  - Reset mid-stream abandons the vector; no further beats of it are emitted. Buffer contents are don't-care.
- States: IDLE and STREAM.
- IDLE:
  - vec_ready=1, s_valid=0.
  - On vec_valid & vec_ready, register vec_in into the buffer, set idx=0 and c=r=x=0, then go to STREAM.
  - First beat is visible the next cycle (1-cycle latency).
- STREAM:
  - s_valid=1.
  - s_data = buffer element idx.
  - s_first = (idx==0), s_last = (idx==DIM-1).
  - s_ch/s_row/s_col = c/r/x.
- Stall: when s_valid & !s_ready, every s_* output holds stable.
- Advance: on s_valid & s_ready with idx<DIM-1, increment idx. x wraps at W-1 into r++, r wraps at H-1 into c++. Counters stay consistent with idx.
- Last beat: on s_valid & s_ready & s_last:
  - If vec_valid=1 in the same cycle, vec_ready=1 (vec_ready = IDLE | (STREAM & s_last & s_ready)). The new vector loads, idx resets to 0, and the block stays in STREAM. This gives back-to-back vectors with no bubble.
  - Otherwise go to IDLE and s_valid drops the next cycle.
- Outside the last beat, vec_ready=0 in STREAM. vec_in changes there are ignored; the buffer never changes mid-stream.
- DIM=1: each beat has s_first=s_last=1.
- Throughput: 1 element/cycle when s_ready is held high. A DIM-element vector occupies exactly DIM cycles of s_valid.

Test Plan:
- Basic order: CH=2, H=2, W=2, vec_in elements i=0..7 = 0x0100*i+i, s_ready=1. Expect 8 beats on consecutive cycles with s_data = 0x0000, 0x0101 … 0x0707. s_first on beat 0 only, s_last on beat 7 only. (ch,row,col) = (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0)…(1,1,1). s_valid low the cycle after beat 7.
- Backpressure: same vector, s_ready pattern 1,0,0,1,0,1,… Each stalled cycle holds s_data/tags unchanged. The beat sequence is identical to the basic test and none is lost or duplicated.
- Back-to-back: vec_valid held high with vector A (all 0x1111), then vector B (all 0x2222) presented during A's last beat. Expect 16 consecutive beats, 8×0x1111 then 8×0x2222. vec_ready pulses exactly on the load cycle and on A's last-beat cycle. s_first is asserted on beat 8.
- Capture isolation: after load, change vec_in to 0xFFFF every cycle while streaming. The emitted data equals the captured vector; vec_ready=0 until the last beat.
- Reset mid-stream: assert rst_n=0 for 1 cycle after beat 3 of 8. The next cycle shows s_valid=0 and vec_ready=1. A fresh vector then streams from element 0 with s_first=1.
- Negative/DIM=1: CH=H=W=1, vec_in=0xFF80 (−0.5). Expect one beat of s_data=0xFF80 with s_first=s_last=1 and tags 0. Then IDLE.

Source files
------------

// File: rtl/flat_vec_streamer.sv
// rtl/flat_vec_streamer.sv - captures one flat CHW vector and replays it one tagged element per beat
module flat_vec_streamer #(
    parameter int CH    = 1,
    parameter int H     = 1,
    parameter int W     = 1,
    parameter int WIDTH = 16,
    localparam int DIM  = CH * H * W,
    localparam int CW   = (CH > 1) ? $clog2(CH) : 1,
    localparam int RW   = (H > 1) ? $clog2(H) : 1,
    localparam int XW   = (W > 1) ? $clog2(W) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   vec_valid,
    output logic                   vec_ready,
    input  logic [DIM*WIDTH-1:0]   vec_in,
    output logic                   s_valid,
    input  logic                   s_ready,
    output logic [WIDTH-1:0]       s_data,
    output logic                   s_first,
    output logic                   s_last,
    output logic [CW-1:0]          s_ch,
    output logic [RW-1:0]          s_row,
    output logic [XW-1:0]          s_col
);

    localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(DIM - 1);
    localparam logic [RW-1:0] R_MAX    = RW'(H - 1);
    localparam logic [XW-1:0] X_MAX    = XW'(W - 1);

    typedef enum logic {ST_IDLE, ST_STREAM} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_buf [DIM];
    logic [IW-1:0]      r_idx;
    logic [CW-1:0]      r_c;
    logic [RW-1:0]      r_r;
    logic [XW-1:0]      r_x;
    logic [WIDTH-1:0]   r_data;
    logic               r_valid;
    logic               r_first;
    logic               r_last;

    logic               w_load;
    logic               w_advance;
    logic               w_finish;
    logic [IW-1:0]      w_idx_nxt;
    logic [WIDTH-1:0]   w_nxt_data;

    // A new vector may be taken while the final beat of the current one is being consumed.
    assign vec_ready = rst_n & ((r_state == ST_IDLE) |
                                ((r_state == ST_STREAM) & r_last & s_ready));
    assign w_load    = vec_valid & vec_ready;
    assign w_advance = (r_state == ST_STREAM) & s_ready & ~r_last;
    assign w_finish  = (r_state == ST_STREAM) & s_ready & r_last;
    assign w_idx_nxt = r_idx + 1'b1;

    always_comb begin
        w_nxt_data = '0;
        for (int i = 0; i < DIM; i++) begin
            if (IW'(i) == w_idx_nxt) begin
                w_nxt_data = r_buf[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            for (int i = 0; i < DIM; i++) begin
                r_buf[i] <= vec_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_c     <= '0;
            r_r     <= '0;
            r_x     <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_load) begin
            r_state <= ST_STREAM;
            r_idx   <= '0;
            r_c     <= '0;
            r_r     <= '0;
            r_x     <= '0;
            r_data  <= vec_in[WIDTH-1:0];
            r_valid <= 1'b1;
            r_first <= 1'b1;
            r_last  <= (DIM == 1);
        end else if (w_advance) begin
            r_idx   <= w_idx_nxt;
            r_data  <= w_nxt_data;
            r_first <= 1'b0;
            r_last  <= (w_idx_nxt == IDX_LAST);
            // Raster order: column fastest, then row, then channel.
            if (r_x == X_MAX) begin
                r_x <= '0;
                if (r_r == R_MAX) begin
                    r_r <= '0;
                    r_c <= r_c + 1'b1;
                end else begin
                    r_r <= r_r + 1'b1;
                end
            end else begin
                r_x <= r_x + 1'b1;
            end
        end else if (w_finish) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign s_valid = r_valid;
    assign s_data  = r_data;
    assign s_first = r_first;
    assign s_last  = r_last;
    assign s_ch    = r_c;
    assign s_row   = r_r;
    assign s_col   = r_x;

endmodule

// File: tb/tb_flat_vec_streamer.sv
// tb/tb_flat_vec_streamer.sv - table and model-checked bench for flat_vec_streamer
module tb_flat_vec_streamer;

    localparam int CH  = 2;
    localparam int H   = 2;
    localparam int W   = 2;
    localparam int WD  = 16;
    localparam int DIM = CH * H * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, vec_valid, vec_ready, s_valid, s_ready, s_first, s_last;
    logic [DIM*WD-1:0] vec_in;
    logic [WD-1:0]     s_data;
    logic              s_ch, s_row, s_col;

    logic              rst1_n, vv1, vr1, sv1, sr1, sf1, sl1, sc1, srow1, scol1;
    logic [WD-1:0]     vin1, sd1;

    flat_vec_streamer #(.CH(CH), .H(H), .W(W), .WIDTH(WD)) u_dut (
        .clk(clk), .rst_n(rst_n), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .vec_in(vec_in), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_first(s_first), .s_last(s_last), .s_ch(s_ch), .s_row(s_row), .s_col(s_col)
    );

    flat_vec_streamer #(.CH(1), .H(1), .W(1), .WIDTH(WD)) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .vec_valid(vv1), .vec_ready(vr1),
        .vec_in(vin1), .s_valid(sv1), .s_ready(sr1), .s_data(sd1),
        .s_first(sf1), .s_last(sl1), .s_ch(sc1), .s_row(srow1), .s_col(scol1)
    );

    int errors = 0;
    int checks = 0;
    int vr_pulses;

    typedef struct {
        int          idx;
        logic [15:0] data;
    } beat_t;
    beat_t q[$];

    typedef struct {
        logic        rst;
        logic        vv;
        logic [15:0] vin;
        logic        srdy;
        logic        exp_vr;
        logic        exp_sv;
        logic [15:0] exp_data;
    } vec1_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input logic rst);
        beat_t b;
        chk("s_valid", {31'd0, s_valid}, {31'd0, q.size() > 0});
        if (q.size() > 0) begin
            b = q[0];
            chk("s_data", {16'd0, s_data}, {16'd0, b.data});
            chk("s_first", {31'd0, s_first}, {31'd0, b.idx == 0});
            chk("s_last", {31'd0, s_last}, {31'd0, b.idx == DIM - 1});
            chk("s_ch", {31'd0, s_ch}, b.idx / (H * W));
            chk("s_row", {31'd0, s_row}, (b.idx / W) % H);
            chk("s_col", {31'd0, s_col}, b.idx % W);
        end else if (!rst) begin
            chk("rst_data", {16'd0, s_data}, 32'd0);
            chk("rst_flags", {28'd0, s_first, s_last, s_ch, s_row}, 32'd0);
        end
    endtask

    // Reference: a queue of pending beats; one vector in flight at most, so a new one
    // is accepted when the queue is empty or only the final beat remains and is taken.
    task automatic step(input logic rst, input logic vv, input logic [DIM*WD-1:0] vin,
                        input logic srdy);
        logic  exp_vr, hs, acc;
        beat_t b;
        rst_n     = rst;
        vec_valid = vv;
        vec_in    = vin;
        s_ready   = srdy;
        #1;
        exp_vr = rst && (q.size() == 0 || (q.size() == 1 && srdy));
        chk("vec_ready", {31'd0, vec_ready}, {31'd0, exp_vr});
        if (vec_ready) vr_pulses++;
        hs  = (q.size() > 0) && srdy;
        acc = vv && exp_vr;
        @(posedge clk);
        #1;
        if (!rst) begin
            q.delete();
        end else begin
            if (hs) q.delete(0);
            if (acc) begin
                for (int i = 0; i < DIM; i++) begin
                    b.idx  = i;
                    b.data = vin[i*WD +: WD];
                    q.push_back(b);
                end
            end
        end
        check_out(rst);
    endtask

    task automatic drain();
        for (int n = 0; n < 64 && q.size() > 0; n++) step(1'b1, 1'b0, '0, 1'b1);
        chk("drain_bound", q.size(), 0);
        step(1'b1, 1'b0, '0, 1'b1);
    endtask

    vec1_t             tbl[9];
    logic [DIM*WD-1:0] va, vb, vc;
    logic [15:0]       pat;

    initial begin
        rst_n = 1'b0; vec_valid = 1'b0; vec_in = '0; s_ready = 1'b0;
        rst1_n = 1'b0; vv1 = 1'b0; vin1 = '0; sr1 = 1'b0;

        tbl[0] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[1] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
        tbl[2] = '{1'b1, 1'b1, 16'hFF80, 1'b0, 1'b1, 1'b1, 16'hFF80};
        tbl[3] = '{1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 16'hFF80};
        tbl[4] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000};
        tbl[5] = '{1'b1, 1'b1, 16'h0042, 1'b1, 1'b1, 1'b1, 16'h0042};
        tbl[6] = '{1'b1, 1'b1, 16'h8001, 1'b1, 1'b1, 1'b1, 16'h8001};
        tbl[7] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000};
        tbl[8] = '{1'b0, 1'b1, 16'h5555, 1'b1, 1'b0, 1'b0, 16'h0000};

        for (int t = 0; t < 9; t++) begin
            rst1_n = tbl[t].rst; vv1 = tbl[t].vv; vin1 = tbl[t].vin; sr1 = tbl[t].srdy;
            #1;
            chk("d1_vec_ready", {31'd0, vr1}, {31'd0, tbl[t].exp_vr});
            @(posedge clk);
            #1;
            chk("d1_s_valid", {31'd0, sv1}, {31'd0, tbl[t].exp_sv});
            if (tbl[t].exp_sv) begin
                chk("d1_s_data", {16'd0, sd1}, {16'd0, tbl[t].exp_data});
                chk("d1_first_last", {30'd0, sf1, sl1}, 32'd3);
                chk("d1_tags", {29'd0, sc1, srow1, scol1}, 32'd0);
            end else if (!tbl[t].rst) begin
                chk("d1_rst_out", {13'd0, sd1, sf1, sl1, sc1}, 32'd0);
            end
        end

        for (int i = 0; i < DIM; i++) va[i*WD +: WD] = 16'(16'h0101 * i);
        for (int i = 0; i < DIM; i++) vb[i*WD +: WD] = 16'h2222;
        for (int i = 0; i < DIM; i++) vc[i*WD +: WD] = 16'h1111;

        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, va, 1'b1);
        drain();

        pat = 16'b1010_0110_1010_1001;
        step(1'b1, 1'b1, va, 1'b0);
        for (int n = 0; n < 64 && q.size() > 0; n++) step(1'b1, 1'b0, '0, pat[n%16]);
        chk("bp_bound", q.size(), 0);
        step(1'b1, 1'b0, '0, 1'b1);

        vr_pulses = 0;
        step(1'b1, 1'b1, vc, 1'b1);
        for (int n = 0; n < DIM - 1; n++) step(1'b1, 1'b1, vc, 1'b1);
        step(1'b1, 1'b1, vb, 1'b1);
        chk("b2b_vr_pulses", vr_pulses, 2);
        drain();

        step(1'b1, 1'b1, va, 1'b1);
        for (int n = 0; n < 4; n++) step(1'b1, 1'b1, {DIM{16'hFFFF}}, 1'b1);
        step(1'b0, 1'b1, {DIM{16'hFFFF}}, 1'b1);
        step(1'b1, 1'b1, vc, 1'b1);
        drain();

        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 63) != 0, 1'($urandom_range(0, 1)),
                 {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3) != 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
